// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, req/ack instruction fetch with timeout, ARM condition evaluation.
// Optional macro IF_COND_CHECK_EN: when defined, flag evaluates cond vs NZCV; otherwise flag is tied to 1.
module inst_fetch_unit #(
   parameter int          ADDR_W   = 6,
   parameter int          TIMEOUT  = 15,
   parameter logic [31:0] UND_WORD = 32'hE7F000F0
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              Write_PC,
   input  logic              Write_IR,
   input  logic [1:0]        PC_s,
   input  logic [31:0]       B,
   input  logic [31:0]       F,
   input  logic [3:0]        NZCV,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       PC,
   output logic [3:0]        condition_code,
   output logic [27:0]       IR,
   output logic              flag,
   output logic              fetch_busy,
   output logic              fetch_done,
   output logic              fetch_err,
   output logic              o_dbg_state
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   localparam logic [7:0] LP_TMO = 8'(TIMEOUT);

   state_t              r_state;
   state_t              w_next;
   logic                w_start;
   logic                w_take;
   logic                w_tmo;
   logic                w_count;
   logic [7:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_pc;
   logic [31:0]         r_inst;
   logic                r_done;
   logic                r_err;

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_take  = 1'b0;
      w_tmo   = 1'b0;
      w_count = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Write_IR) begin
               w_start = 1'b1;
               w_next  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               w_take = 1'b1;
               w_next = S_IDLE;
            end else if (r_cnt == LP_TMO) begin
               w_tmo  = 1'b1;
               w_next = S_IDLE;
            end else begin
               w_count = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Address is captured at fetch start so PC updates during WAIT cannot disturb it.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         r_cnt  <= 8'd0;
         r_addr <= '0;
         r_inst <= {4'hE, 28'd0};
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_done <= w_take | w_tmo;
         r_err  <= w_tmo;
         if (w_start) begin
            r_addr <= r_pc[ADDR_W+1:2];
            r_cnt  <= 8'd0;
         end else if (w_count && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_take)     r_inst <= mem_rdata;
         else if (w_tmo) r_inst <= UND_WORD;
      end
   end

   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         r_pc <= 32'd0;
      end else if (Write_PC) begin
         case (PC_s)
            2'b00:   r_pc <= r_pc + 32'd4;
            2'b01:   r_pc <= {B[31:2], 2'b00};
            2'b10:   r_pc <= F;
            default: r_pc <= r_pc;
         endcase
      end
   end

   assign mem_req        = (r_state == S_WAIT);
   assign fetch_busy     = (r_state == S_WAIT);
   assign o_dbg_state    = r_state;
   assign mem_addr       = r_addr;
   assign PC             = r_pc;
   assign condition_code = r_inst[31:28];
   assign IR             = r_inst[27:0];
   assign fetch_done     = r_done;
   assign fetch_err      = r_err;

`ifdef IF_COND_CHECK_EN
   logic w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = NZCV;

   always_comb begin
      flag = 1'b0;
      case (condition_code)
         4'h0: flag = w_z;
         4'h1: flag = ~w_z;
         4'h2: flag = w_c;
         4'h3: flag = ~w_c;
         4'h4: flag = w_n;
         4'h5: flag = ~w_n;
         4'h6: flag = w_v;
         4'h7: flag = ~w_v;
         4'h8: flag = w_c & ~w_z;
         4'h9: flag = ~w_c | w_z;
         4'hA: flag = (w_n == w_v);
         4'hB: flag = (w_n != w_v);
         4'hC: flag = ~w_z & (w_n == w_v);
         4'hD: flag = w_z | (w_n != w_v);
         4'hE: flag = 1'b1;
         default: flag = 1'b0;
      endcase
   end
`else
   logic w_unused_nzcv;
   assign w_unused_nzcv = ^NZCV;
   assign flag = 1'b1;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit: reset, fetch latency, PC sources, wait states, timeout, flag, reset abort.
module tb_inst_fetch_unit;

   logic        clk;
   logic        Rst;
   logic        Write_PC;
   logic        Write_IR;
   logic [1:0]  PC_s;
   logic [31:0] B;
   logic [31:0] F;
   logic [3:0]  NZCV;
   logic        mem_req;
   logic [5:0]  mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] PC;
   logic [3:0]  condition_code;
   logic [27:0] IR;
   logic        flag;
   logic        fetch_busy;
   logic        fetch_done;
   logic        fetch_err;
   logic        o_dbg_state;

   int errors = 0;
   int checks = 0;

`ifdef IF_COND_CHECK_EN
   localparam logic COND_ON = 1'b1;
`else
   localparam logic COND_ON = 1'b0;
`endif

   inst_fetch_unit #(.ADDR_W(6), .TIMEOUT(15), .UND_WORD(32'hE7F000F0)) dut (
      .clk(clk), .Rst(Rst), .Write_PC(Write_PC), .Write_IR(Write_IR), .PC_s(PC_s),
      .B(B), .F(F), .NZCV(NZCV), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .PC(PC), .condition_code(condition_code),
      .IR(IR), .flag(flag), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
      .fetch_err(fetch_err), .o_dbg_state(o_dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int seen;
      Rst = 1'b1; Write_PC = 1'b0; Write_IR = 1'b0; PC_s = 2'b11;
      B = '0; F = '0; NZCV = 4'b0000; mem_ack = 1'b0; mem_rdata = '0;
      @(negedge clk); @(negedge clk);
      check("rst_pc", PC, 32'd0);
      check("rst_ir", {condition_code, IR}, 32'hE0000000);
      check("rst_req", {mem_req, fetch_busy, fetch_done, fetch_err}, 4'b0000);
      check("rst_addr", mem_addr, 6'd0);
      check("rst_flag", flag, 1'b1);
      Rst = 1'b0;
      @(negedge clk);

      // Zero-wait fetch
      Write_IR = 1'b1;
      tick();
      Write_IR = 1'b0;
      check("f1_req", {mem_req, fetch_busy}, 2'b11);
      check("f1_addr", mem_addr, 6'd0);
      check("f1_done_early", fetch_done, 1'b0);
      mem_ack = 1'b1; mem_rdata = 32'hE0810002;
      tick();
      mem_ack = 1'b0;
      check("f1_done", fetch_done, 1'b1);
      check("f1_cond", condition_code, 4'hE);
      check("f1_ir", IR, 28'h0810002);
      check("f1_req_off", mem_req, 1'b0);
      check("f1_flag", flag, 1'b1);
      tick();
      check("f1_done_pulse", fetch_done, 1'b0);

      // PC sources
      Write_PC = 1'b1; PC_s = 2'b00;
      tick(); tick();
      check("pc_inc2", PC, 32'h8);
      Write_IR = 1'b1;
      tick();
      Write_IR = 1'b0; Write_PC = 1'b0;
      check("pc_same_addr", mem_addr, 6'd2);
      check("pc_same_pc", PC, 32'hC);
      mem_ack = 1'b1; mem_rdata = 32'h01234567;
      tick();
      mem_ack = 1'b0;
      check("eq_word", {condition_code, IR}, 32'h01234567);
      NZCV = 4'b0100; #1;
      check("eq_z1", flag, 1'b1);
      NZCV = 4'b0000; #1;
      check("eq_z0", flag, COND_ON ? 1'b0 : 1'b1);
      Write_PC = 1'b1; PC_s = 2'b01; B = 32'h23;
      tick();
      check("pc_b", PC, 32'h20);
      PC_s = 2'b10; F = 32'h40;
      tick();
      check("pc_f", PC, 32'h40);
      PC_s = 2'b11;
      tick();
      check("pc_hold", PC, 32'h40);
      PC_s = 2'b10; F = 32'hFFFFFFFC;
      tick();
      PC_s = 2'b00;
      tick();
      check("pc_wrap", PC, 32'h0);
      PC_s = 2'b10; F = 32'h44;
      tick();
      Write_PC = 1'b0;

      // Three wait states, stray Write_IR and PC change during WAIT
      Write_IR = 1'b1;
      tick();
      Write_IR = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("w_req", {mem_req, fetch_done}, 2'b10);
         check("w_addr", mem_addr, 6'h11);
         if (i == 1) begin
            Write_IR = 1'b1; Write_PC = 1'b1; PC_s = 2'b10; F = 32'h80;
         end else begin
            Write_IR = 1'b0; Write_PC = 1'b0;
         end
         tick();
      end
      check("w_req4", mem_req, 1'b1);
      check("w_addr4", mem_addr, 6'h11);
      check("w_pc_moved", PC, 32'h80);
      mem_ack = 1'b1; mem_rdata = 32'hC0000000;
      tick();
      mem_ack = 1'b0;
      check("w_done", {fetch_done, mem_req, fetch_err}, 3'b100);
      NZCV = 4'b1001; #1;
      check("gt_flag", flag, 1'b1);
      tick();
      check("w_done_pulse", {fetch_done, mem_req}, 2'b00);

      // Timeout
      Write_IR = 1'b1;
      tick();
      Write_IR = 1'b0;
      seen = 0;
      for (int c = 1; c <= 40 && seen == 0; c++) begin
         if (fetch_err) seen = c;
         else tick();
      end
      check("tmo_cycle", seen, 17);
      check("tmo_done", {fetch_done, fetch_err}, 2'b11);
      check("tmo_word", {condition_code, IR}, 32'hE7F000F0);
      check("tmo_flag", flag, 1'b1);
      tick();
      check("tmo_pulse", {fetch_err, fetch_done, mem_req}, 3'b000);

      // Condition 1111
      Write_IR = 1'b1;
      tick();
      Write_IR = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hF0000000;
      tick();
      mem_ack = 1'b0;
      check("nv_flag", flag, COND_ON ? 1'b0 : 1'b1);

      // Reset during WAIT
      Write_IR = 1'b1;
      tick();
      Write_IR = 1'b0;
      check("ra_req", mem_req, 1'b1);
      #2 Rst = 1'b1;
      #1;
      check("ra_req_off", mem_req, 1'b0);
      check("ra_pc", PC, 32'd0);
      @(negedge clk);
      Rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_ack = 1'b0;
      check("ra_ir", {condition_code, IR}, 32'hE0000000);
      check("ra_done", {fetch_done, mem_req}, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
